inst_encoder: RTL and testbench

Instruction encoder and loader for the RV64 subset the core executes: ld, sd, and, or, add, sub, beq, blt. It accepts one decoded operation per valid/ready beat, packs it into a 32-bit instruction word bit-exact with the core's instruction decoder, and buffers it in a small FIFO. It then writes the words to consecutive instruction-memory addresses. It sits between the test/boot program source and the instruction memory.

---
 rtl/inst_encoder.sv | 176 +++++++++++++++++
 tb/tb_inst_encoder.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// Encodes decoded RV64-subset operations into 32-bit instruction words and writes them to imem.
// Optional: define INST_ENCODER_RD0_CHECK_EN to squash rd=0 writers to a no-op and flag err_rd0.
module inst_encoder #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_imm,
    input  logic              in_dir,
    input  logic              in_last,
    input  logic              imem_stall,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              wrapped
`ifdef INST_ENCODER_RD0_CHECK_EN
    ,
    output logic              err_rd0
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [31:0]       raw_word;
    logic [31:0]       enc_word;
    logic [31:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nx;
    logic [ADDR_W-1:0] addr;
    logic              push;
    logic              pop;
    logic              in_ready_nx;
    logic              busy_nx;
    logic              done_nx;

    assign push = in_valid && in_ready;
    assign pop  = ((state == S_RUN) || (state == S_DRAIN)) && (count != '0) && !imem_stall;

    // Field packing, bit-exact with the core's decoder
    always_comb begin
        raw_word = '0;
        case (in_op)
            3'd0: raw_word = {7'b0000000, in_imm, in_rs1, 3'b011, in_rd, OPC_LOAD};
            3'd1: raw_word = {7'b0000000, in_rs2, in_rs1, 3'b011, in_imm, OPC_STORE};
            3'd2: raw_word = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OPC_OP};
            3'd3: raw_word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OPC_OP};
            3'd4: raw_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_OP};
            3'd5: raw_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OPC_OP};
            3'd6: raw_word = {6'b000000, in_dir, in_rs2, in_rs1, 3'b000, in_imm, OPC_BRANCH};
            3'd7: raw_word = {6'b000000, in_dir, in_rs2, in_rs1, 3'b100, in_imm, OPC_BRANCH};
            default: raw_word = '0;
        endcase
    end

`ifdef INST_ENCODER_RD0_CHECK_EN
    logic rd0_hit;
    assign rd0_hit  = ((in_op == 3'd0) || ((in_op >= 3'd2) && (in_op <= 3'd5))) && (in_rd == 5'd0);
    assign enc_word = rd0_hit ? 32'h0000_0000 : raw_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_rd0 <= 1'b0;
        end else if ((state == S_IDLE) && start) begin
            err_rd0 <= 1'b0;
        end else if (push && rd0_hit) begin
            err_rd0 <= 1'b1;
        end
    end
`else
    assign enc_word = raw_word;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start)            state_nx = S_RUN;
            S_RUN:   if (push && in_last)  state_nx = S_DRAIN;
            S_DRAIN: if (count == '0)      state_nx = S_DONE;
            S_DONE:                        state_nx = S_IDLE;
            default:                       state_nx = S_IDLE;
        endcase
    end

    // Output decode from the next state so the status flops line up with the state register
    always_comb begin
        count_nx = count;
        if (push && !pop)      count_nx = count + CNT_W'(1);
        else if (pop && !push) count_nx = count - CNT_W'(1);
        in_ready_nx = (state_nx == S_RUN) && (count_nx != FULL_CNT);
        busy_nx     = (state_nx == S_RUN) || (state_nx == S_DRAIN);
        done_nx     = (state_nx == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            in_ready <= in_ready_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nx;
        end
    end

    // Write port and address sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            wrapped    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= pop;
            if ((state == S_IDLE) && start) begin
                addr    <= base_addr;
                wrapped <= 1'b0;
            end else if (pop) begin
                addr       <= addr + ADDR_W'(1);
                imem_addr  <= addr;
                imem_wdata <= mem[rd_ptr];
                if (&addr) wrapped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios plus randomized sessions
// checked against an arithmetic encoding model and an address/order scoreboard.
module tb_inst_encoder;

    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [4:0]    in_imm;
    logic          in_dir;
    logic          in_last;
    logic          imem_stall;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          wrapped;
`ifdef INST_ENCODER_RD0_CHECK_EN
    logic          err_rd0;
    bit            exp_err;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_we_cyc = -1;
    int exp_base = 0;
    logic [AW-1:0] obs_addr[$];
    logic [31:0]   obs_data[$];
    logic [31:0]   exp_data[$];

    inst_encoder #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_dir(in_dir),
        .in_last(in_last), .imem_stall(imem_stall), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
        .done(done), .wrapped(wrapped)
`ifdef INST_ENCODER_RD0_CHECK_EN
        , .err_rd0(err_rd0)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (imem_we) begin
            obs_addr.push_back(imem_addr);
            obs_data.push_back(imem_wdata);
            last_we_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference encoding built from the instruction field table
    function automatic logic [31:0] model_enc(input int op, rd, rs1, rs2, imm, dir);
        int opc, f3, f7, lo, hi;
        f7 = 0;
        case (op)
            0: begin opc = 3;  f3 = 3; lo = rd;  hi = imm; end
            1: begin opc = 35; f3 = 3; lo = imm; hi = rs2; end
            2: begin opc = 51; f3 = 7; lo = rd;  hi = rs2; end
            3: begin opc = 51; f3 = 6; lo = rd;  hi = rs2; end
            4: begin opc = 51; f3 = 0; lo = rd;  hi = rs2; end
            5: begin opc = 51; f3 = 0; lo = rd;  hi = rs2; f7 = 32; end
            6: begin opc = 99; f3 = 0; lo = imm; hi = rs2; f7 = dir; end
            default: begin opc = 99; f3 = 4; lo = imm; hi = rs2; f7 = dir; end
        endcase
`ifdef INST_ENCODER_RD0_CHECK_EN
        if ((op == 0 || (op >= 2 && op <= 5)) && rd == 0) return 32'h0;
`endif
        return 32'(f7 * (2 ** 25) + hi * (2 ** 20) + rs1 * (2 ** 15) + f3 * (2 ** 12) + lo * (2 ** 7) + opc);
    endfunction

    task automatic start_session(input int base);
        obs_addr.delete();
        obs_data.delete();
        exp_data.delete();
        done_cnt = 0;
        exp_base = base;
`ifdef INST_ENCODER_RD0_CHECK_EN
        exp_err = 1'b0;
`endif
        @(negedge clk);
        start = 1'b1;
        base_addr = AW'(base);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || wrapped !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_state: got ready=%b wrapped=%b busy=%b expected 1 0 1", in_ready, wrapped, busy);
        end
`ifdef INST_ENCODER_RD0_CHECK_EN
        checks++;
        if (err_rd0 !== 1'b0) begin failures++; $display("FAIL start_err_rd0: got %b expected 0", err_rd0); end
`endif
    endtask

    task automatic drive_fields(input int op, rd, rs1, rs2, imm, dir, input bit last);
        in_op = 3'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
        in_imm = 5'(imm); in_dir = 1'(dir); in_last = last; in_valid = 1'b1;
        exp_data.push_back(model_enc(op, rd, rs1, rs2, imm, dir));
`ifdef INST_ENCODER_RD0_CHECK_EN
        if ((op == 0 || (op >= 2 && op <= 5)) && rd == 0) exp_err = 1'b1;
`endif
    endtask

    task automatic send_beat(input int op, rd, rs1, rs2, imm, dir, input bit last);
        int t = 0;
        @(negedge clk);
        drive_fields(op, rd, rs1, rs2, imm, dir, last);
        while (in_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin
            checks++; failures++;
            $display("FAIL send_timeout: got in_ready=%b expected 1 within 100 cycles", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_random(input bit last);
        send_beat($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1), last);
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt == 0 && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (done_cnt == 0) begin failures++; $display("FAIL done_timeout: got no done expected a pulse"); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_op = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_dir = 1'b0; in_last = 1'b0;
        imem_stall = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, imem_we, busy, done, wrapped} !== 5'b0) begin
            failures++; $display("FAIL reset_flags: got %b expected 00000", {in_ready, imem_we, busy, done, wrapped});
        end
        checks++;
        if (imem_addr !== '0 || imem_wdata !== '0) begin
            failures++; $display("FAIL reset_bus: got addr=%h data=%h expected 0 0", imem_addr, imem_wdata);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset: got ready=%b busy=%b expected 0 0", in_ready, busy);
        end
    endtask

    task automatic test_single_add();
        start_session(2);
        send_beat(4, 3, 1, 2, 0, 0, 1'b1);
        wait_done();
        checks++;
        if (obs_data.size() != 1 || obs_addr[0] !== 5'd2 || obs_data[0] !== 32'h002081B3) begin
            failures++; $display("FAIL add_write: got n=%0d addr=%h data=%h expected 1 02 002081b3",
                                 obs_data.size(), obs_addr[0], obs_data[0]);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_we_cyc + 1) begin
            failures++; $display("FAIL add_done: got pulses=%0d cyc=%0d expected 1 %0d", done_cnt, done_cyc, last_we_cyc + 1);
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL add_idle: got busy=%b ready=%b expected 0 0", busy, in_ready);
        end
    endtask

    task automatic test_sub_beq();
        int b = $urandom_range(0, 30);
        start_session(b);
        send_beat(5, 5, 6, 7, 0, 0, 1'b0);
        send_beat(6, 0, 1, 2, 4, 1, 1'b1);
        wait_done();
        checks++;
        if (obs_data.size() != 2 || obs_data[0] !== 32'h407302B3 || obs_data[1] !== 32'h02208263) begin
            failures++; $display("FAIL subbeq_data: got n=%0d %h %h expected 2 407302b3 02208263",
                                 obs_data.size(), obs_data[0], obs_data[1]);
        end
        checks++;
        if (obs_addr[0] !== AW'(b) || obs_addr[1] !== AW'(b + 1)) begin
            failures++; $display("FAIL subbeq_addr: got %h %h expected %h %h", obs_addr[0], obs_addr[1], AW'(b), AW'(b + 1));
        end
    endtask

    task automatic test_stall_full();
        int t = 0;
        imem_stall = 1'b1;
        start_session($urandom_range(0, 31));
        for (int i = 0; i < 4; i++) send_random(1'b0);
        @(negedge clk);
        drive_fields($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1), 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready: got %b expected 0", in_ready); end
            @(negedge clk);
        end
        checks++;
        if (obs_data.size() != 0) begin failures++; $display("FAIL stall_write: got %0d writes expected 0", obs_data.size()); end
        imem_stall = 1'b0;
        while (in_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done();
        checks++;
        if (obs_data.size() != 5) begin failures++; $display("FAIL stall_count: got %0d expected 5", obs_data.size()); end
        foreach (exp_data[i]) if (i < obs_data.size()) begin
            checks++;
            if (obs_addr[i] !== AW'(exp_base + i) || obs_data[i] !== exp_data[i]) begin
                failures++; $display("FAIL stall_word%0d: got %h@%h expected %h@%h", i, obs_data[i], obs_addr[i], exp_data[i], AW'(exp_base + i));
            end
        end
    endtask

    task automatic test_wrap();
        start_session(31);
        send_random(1'b0);
        send_random(1'b1);
        wait_done();
        checks++;
        if (obs_data.size() != 2 || obs_addr[0] !== 5'd31 || obs_addr[1] !== 5'd0
            || obs_data[0] !== exp_data[0] || obs_data[1] !== exp_data[1]) begin
            failures++; $display("FAIL wrap_writes: got n=%0d %h@%h %h@%h expected %h@1f %h@00", obs_data.size(),
                                 obs_data[0], obs_addr[0], obs_data[1], obs_addr[1], exp_data[0], exp_data[1]);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (wrapped !== 1'b1) begin failures++; $display("FAIL wrap_sticky: got %b expected 1", wrapped); end
        start_session(0);
        send_random(1'b1);
        wait_done();
        checks++;
        if (wrapped !== 1'b0) begin failures++; $display("FAIL wrap_clear: got %b expected 0", wrapped); end
    endtask

    task automatic test_rd0();
        logic [31:0] lit;
`ifdef INST_ENCODER_RD0_CHECK_EN
        lit = 32'h0000_0000;
`else
        lit = 32'h0030B003;
`endif
        start_session(9);
        send_beat(0, 0, 1, 0, 3, 0, 1'b1);
        wait_done();
        checks++;
        if (obs_data.size() != 1 || obs_data[0] !== lit) begin
            failures++; $display("FAIL rd0_word: got n=%0d %h expected 1 %h", obs_data.size(), obs_data[0], lit);
        end
`ifdef INST_ENCODER_RD0_CHECK_EN
        checks++;
        if (err_rd0 !== 1'b1) begin failures++; $display("FAIL rd0_flag: got %b expected 1", err_rd0); end
`endif
    endtask

    task automatic test_random_sessions();
        for (int s = 0; s < 6; s++) begin
            int n = $urandom_range(1, 9);
            bit sent = 1'b0;
            start_session($urandom_range(0, 31));
            fork
                begin
                    for (int i = 0; i < n; i++) send_random(i == n - 1);
                    sent = 1'b1;
                end
                begin
                    while (!sent) begin
                        @(negedge clk);
                        imem_stall = ($urandom_range(0, 2) == 0);
                    end
                end
            join
            imem_stall = 1'b0;
            wait_done();
            checks++;
            if (obs_data.size() != n || done_cnt != 1 || done_cyc != last_we_cyc + 1) begin
                failures++; $display("FAIL rand%0d_session: got n=%0d done=%0d@%0d expected %0d 1@%0d",
                                     s, obs_data.size(), done_cnt, done_cyc, n, last_we_cyc + 1);
            end
            foreach (exp_data[i]) if (i < obs_data.size()) begin
                checks++;
                if (obs_addr[i] !== AW'(exp_base + i) || obs_data[i] !== exp_data[i]) begin
                    failures++; $display("FAIL rand%0d_word%0d: got %h@%h expected %h@%h", s, i,
                                         obs_data[i], obs_addr[i], exp_data[i], AW'(exp_base + i));
                end
            end
`ifdef INST_ENCODER_RD0_CHECK_EN
            checks++;
            if (err_rd0 !== exp_err) begin failures++; $display("FAIL rand%0d_err_rd0: got %b expected %b", s, err_rd0, exp_err); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        int n_before;
        imem_stall = 1'b1;
        start_session($urandom_range(0, 31));
        for (int i = 0; i < 3; i++) send_random(1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, imem_we, busy, done, wrapped} !== 5'b0 || imem_addr !== '0 || imem_wdata !== '0) begin
            failures++; $display("FAIL midreset_outputs: got flags=%b addr=%h data=%h expected 0 0 0",
                                 {in_ready, imem_we, busy, done, wrapped}, imem_addr, imem_wdata);
        end
        imem_stall = 1'b0;
        n_before = obs_data.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (obs_data.size() != n_before || busy !== 1'b0) begin
            failures++; $display("FAIL midreset_quiet: got writes=%0d busy=%b expected %0d 0", obs_data.size(), busy, n_before);
        end
        start_session(7);
        send_beat(4, 3, 1, 2, 0, 0, 1'b0);
        send_random(1'b1);
        wait_done();
        checks++;
        if (obs_data.size() != 2 || obs_addr[0] !== 5'd7 || obs_data[0] !== 32'h002081B3
            || obs_addr[1] !== 5'd8 || obs_data[1] !== exp_data[1]) begin
            failures++; $display("FAIL midreset_restart: got n=%0d %h@%h %h@%h expected 2 002081b3@07 %h@08",
                                 obs_data.size(), obs_data[0], obs_addr[0], obs_data[1], obs_addr[1], exp_data[1]);
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_sub_beq();
        test_stall_full();
        test_wrap();
        test_rd0();
        test_random_sessions();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
